// File: rtl/sample_feeder_if.sv
// Sample-feed link: sample RAM read port plus the slow waveforms presented to the channel top.
interface sample_feeder_if #(
  parameter int unsigned INPUT_WIDTH = 3,
  parameter int unsigned LEN_WIDTH   = 16
);
  logic                   rd_en;
  logic [LEN_WIDTH-1:0]   rd_addr;
  logic [INPUT_WIDTH-1:0] rd_data;
  logic                   clk_sample;
  logic                   sample_valid;
  logic                   feed_reset;
  logic                   feed_complete;
  logic [INPUT_WIDTH-1:0] data;

  modport master (
    output rd_en, rd_addr, clk_sample, sample_valid, feed_reset, feed_complete, data,
    input  rd_data
  );

  modport slave (
    input  rd_en, rd_addr, clk_sample, sample_valid, feed_reset, feed_complete, data,
    output rd_data
  );
endinterface

// File: rtl/sample_feeder.sv
// Replays a block of recorded IF samples from a synchronous RAM as slow, glitch-free
// clk_sample/data waveforms that a double-flop synchronizing receiver can consume.
module sample_feeder #(
  parameter int unsigned INPUT_WIDTH = 3,
  parameter int unsigned LEN_WIDTH   = 16,
  parameter int unsigned DIV         = 4,
  parameter int unsigned CTRL_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] num_samples,
  output logic                 busy,
  output logic                 done,
  sample_feeder_if.master      feed
);

  localparam int unsigned TMR_MAX = (DIV > CTRL_CYCLES) ? DIV : CTRL_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX);
  localparam int unsigned CNT_W   = LEN_WIDTH + 1;
  localparam logic [TMR_W-1:0] DIV_LAST  = TMR_W'(DIV - 1);
  localparam logic [TMR_W-1:0] DIV_PRE   = TMR_W'(DIV - 2);
  localparam logic [TMR_W-1:0] CTRL_LAST = TMR_W'(CTRL_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_LOAD, S_LOW, S_HIGH, S_TAIL, S_CMPL
  } state_t;

  state_t                 state;
  logic [TMR_W-1:0]       tmr;
  logic [LEN_WIDTH-1:0]   cnt;
  logic [LEN_WIDTH-1:0]   idx;
  logic                   rd_en;
  logic [LEN_WIDTH-1:0]   rd_addr;
  logic                   clk_sample;
  logic                   sample_valid;
  logic                   feed_reset;
  logic                   feed_complete;
  logic [INPUT_WIDTH-1:0] data;
  logic                   more_c;

  // Compared one bit wider so idx+1 cannot wrap when cnt is all ones.
  assign more_c = (CNT_W'(idx) + CNT_W'(1)) < CNT_W'(cnt);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      tmr           <= '0;
      cnt           <= '0;
      idx           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      rd_en         <= 1'b0;
      rd_addr       <= '0;
      clk_sample    <= 1'b0;
      sample_valid  <= 1'b0;
      feed_reset    <= 1'b0;
      feed_complete <= 1'b0;
      data          <= '0;
    end else begin
      done  <= 1'b0;
      rd_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt        <= num_samples;
            idx        <= '0;
            tmr        <= '0;
            busy       <= 1'b1;
            feed_reset <= 1'b1;
            state      <= S_RST;
          end
        end
        S_RST: begin
          if (tmr == CTRL_LAST) begin
            tmr        <= '0;
            feed_reset <= 1'b0;
            if (cnt == '0) begin
              feed_complete <= 1'b1;
              state         <= S_CMPL;
            end else begin
              rd_en   <= 1'b1;
              rd_addr <= idx;
              state   <= S_LOAD;
            end
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end
        S_LOAD: begin
          tmr          <= '0;
          sample_valid <= 1'b1;
          state        <= S_LOW;
        end
        S_LOW: begin
          // RAM data lands during the first LOW cycle, one cycle after the falling edge.
          if (tmr == '0) data <= feed.rd_data;
          if (tmr == DIV_LAST) begin
            tmr        <= '0;
            clk_sample <= 1'b1;
            state      <= S_HIGH;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end
        S_HIGH: begin
          // The next read is issued so it is visible in the last HIGH cycle; that same
          // registered strobe then decides between another sample and the tail.
          if (tmr == DIV_LAST) begin
            tmr        <= '0;
            clk_sample <= 1'b0;
            if (rd_en) begin
              state <= S_LOW;
            end else begin
              sample_valid <= 1'b0;
              state        <= S_TAIL;
            end
          end else begin
            tmr <= tmr + TMR_W'(1);
            if (tmr == DIV_PRE && more_c) begin
              rd_en   <= 1'b1;
              rd_addr <= idx + LEN_WIDTH'(1);
              idx     <= idx + LEN_WIDTH'(1);
            end
          end
        end
        S_TAIL: begin
          if (tmr == DIV_LAST) begin
            tmr           <= '0;
            feed_complete <= 1'b1;
            state         <= S_CMPL;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end
        S_CMPL: begin
          if (tmr == CTRL_LAST) begin
            tmr           <= '0;
            feed_complete <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b1;
            state         <= S_IDLE;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign feed.rd_en         = rd_en;
  assign feed.rd_addr       = rd_addr;
  assign feed.clk_sample    = clk_sample;
  assign feed.sample_valid  = sample_valid;
  assign feed.feed_reset    = feed_reset;
  assign feed.feed_complete = feed_complete;
  assign feed.data          = data;

endmodule

// File: tb/tb_sample_feeder.sv
// Directed bench for sample_feeder: cycle-exact timelines against hand-derived expectations
// plus a long loopback through a receiver-style synchronizer.
module tb_sample_feeder;

  localparam int unsigned IW  = 3;
  localparam int unsigned LW  = 16;
  localparam int unsigned DIV = 4;
  localparam int unsigned CC  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [LW-1:0] num_samples;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;

  sample_feeder_if #(.INPUT_WIDTH(IW), .LEN_WIDTH(LW)) fi ();

  sample_feeder #(
    .INPUT_WIDTH(IW), .LEN_WIDTH(LW), .DIV(DIV), .CTRL_CYCLES(CC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_samples (num_samples),
    .busy        (busy),
    .done        (done),
    .feed        (fi)
  );

  always #5 clk = ~clk;

  // Synchronous sample RAM model
  logic [IW-1:0] ram [0:1023];
  always @(posedge clk) if (fi.rd_en) fi.rd_data <= ram[fi.rd_addr[9:0]];

  // Channel-top-style receiver: 2-flop synchronizers and rising-edge strobe
  logic [2:0]    sc;
  logic [1:0]    sv, sfc;
  logic [IW-1:0] sd0, sd1;
  logic          lb_en = 1'b0;
  logic          lb_clr = 1'b0;
  int            lb_count, lb_bad_valid;
  logic [IW-1:0] lb_cap [0:1023];

  always @(posedge clk) begin
    sc  <= {sc[1:0], fi.clk_sample};
    sv  <= {sv[0], fi.sample_valid};
    sfc <= {sfc[0], fi.feed_complete};
    sd0 <= fi.data;
    sd1 <= sd0;
    if (lb_clr) begin
      lb_count     <= 0;
      lb_bad_valid <= 0;
    end else if (lb_en && sc[1] && !sc[2]) begin
      if (lb_count < 1024) lb_cap[lb_count] <= sd1;
      if (!sv[1]) lb_bad_valid <= lb_bad_valid + 1;
      lb_count <= lb_count + 1;
    end
  end

  typedef struct packed {
    logic [6:0]    flags;  // busy, done, rd_en, clk_sample, sample_valid, feed_reset, feed_complete
    logic [LW-1:0] addr;
    logic          chk;
    logic [IW-1:0] data;
  } exp_t;

  function automatic logic [6:0] flags_now();
    return {busy, done, fi.rd_en, fi.clk_sample, fi.sample_valid, fi.feed_reset, fi.feed_complete};
  endfunction

  // Expected timeline of the N=3, RAM=[5,2,7] feed with start sampled in cycle 0
  function automatic exp_t exp_basic(input int c);
    exp_t e;
    e = '0;
    e.flags[6] = (c >= 1 && c <= 37);
    e.flags[5] = (c == 38);
    if (c == 5 || c == 13 || c == 21) begin
      e.flags[4] = 1'b1;
      e.addr     = LW'((c - 5) / 8);
    end
    e.flags[3] = (c >= 10 && c <= 29 && ((c - 10) % 8) < 4);
    e.flags[2] = (c >= 6 && c <= 29);
    e.flags[1] = (c >= 1 && c <= 4);
    e.flags[0] = (c >= 34 && c <= 37);
    if (c >= 7 && c <= 13)  begin e.chk = 1'b1; e.data = 3'd5; end
    if (c >= 15 && c <= 21) begin e.chk = 1'b1; e.data = 3'd2; end
    if (c >= 23 && c <= 33) begin e.chk = 1'b1; e.data = 3'd7; end
    return e;
  endfunction

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; num_samples = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (flags_now() !== 7'b0 || fi.rd_addr !== '0 || fi.data !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: flags=%b addr=%0d data=%0d, want all 0", flags_now(), fi.rd_addr, fi.data);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (flags_now() !== 7'b0 || fi.rd_addr !== '0 || fi.data !== '0) begin
      n_fail++;
      $display("FAIL reset_idle: flags=%b addr=%0d data=%0d, want all 0", flags_now(), fi.rd_addr, fi.data);
    end
  endtask

  task automatic test_basic_feed();
    exp_t e;
    ram[0] = 3'd5; ram[1] = 3'd2; ram[2] = 3'd7;
    @(negedge clk);
    start = 1'b1; num_samples = LW'(3);
    for (int c = 1; c <= 42; c++) begin
      @(negedge clk);
      start = 1'b0;
      e = exp_basic(c);
      n_checks++;
      if (flags_now() !== e.flags) begin
        n_fail++;
        $display("FAIL basic_flags c=%0d: got %b want %b", c, flags_now(), e.flags);
      end
      if (e.flags[4]) begin
        n_checks++;
        if (fi.rd_addr !== e.addr) begin
          n_fail++;
          $display("FAIL basic_addr c=%0d: got %0d want %0d", c, fi.rd_addr, e.addr);
        end
      end
      if (e.chk) begin
        n_checks++;
        if (fi.data !== e.data) begin
          n_fail++;
          $display("FAIL basic_data c=%0d: got %0d want %0d", c, fi.data, e.data);
        end
      end
    end
  endtask

  task automatic test_zero_length();
    logic [6:0] want;
    @(negedge clk);
    start = 1'b1; num_samples = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      start = 1'b0;
      want = {(c >= 1 && c <= 8), (c == 9), 1'b0, 1'b0, 1'b0, (c >= 1 && c <= 4), (c >= 5 && c <= 8)};
      n_checks++;
      if (flags_now() !== want) begin
        n_fail++;
        $display("FAIL zero_len_flags c=%0d: got %b want %b", c, flags_now(), want);
      end
    end
  endtask

  task automatic test_start_while_busy();
    exp_t e;
    @(negedge clk);
    start = 1'b1; num_samples = LW'(3);
    for (int c = 1; c <= 42; c++) begin
      @(negedge clk);
      e = exp_basic(c);
      n_checks++;
      if (flags_now() !== e.flags) begin
        n_fail++;
        $display("FAIL busy_start_flags c=%0d: got %b want %b", c, flags_now(), e.flags);
      end
      if (e.flags[4]) begin
        n_checks++;
        if (fi.rd_addr !== e.addr) begin
          n_fail++;
          $display("FAIL busy_start_addr c=%0d: got %0d want %0d", c, fi.rd_addr, e.addr);
        end
      end
      if (e.chk) begin
        n_checks++;
        if (fi.data !== e.data) begin
          n_fail++;
          $display("FAIL busy_start_data c=%0d: got %0d want %0d", c, fi.data, e.data);
        end
      end
      start = (c == 3 || c == 20);
      if (c == 3) num_samples = LW'(9);
    end
  endtask

  task automatic test_reset_mid_feed();
    exp_t e;
    @(negedge clk);
    start = 1'b1; num_samples = LW'(3);
    for (int c = 1; c <= 62; c++) begin
      @(negedge clk);
      if (c <= 15)      e = exp_basic(c);
      else if (c <= 20) begin e = '0; e.chk = 1'b1; end
      else              e = exp_basic(c - 20);
      n_checks++;
      if (flags_now() !== e.flags) begin
        n_fail++;
        $display("FAIL rst_mid_flags c=%0d: got %b want %b", c, flags_now(), e.flags);
      end
      if (e.flags[4] || (c >= 16 && c <= 20)) begin
        n_checks++;
        if (fi.rd_addr !== e.addr) begin
          n_fail++;
          $display("FAIL rst_mid_addr c=%0d: got %0d want %0d", c, fi.rd_addr, e.addr);
        end
      end
      if (e.chk) begin
        n_checks++;
        if (fi.data !== e.data) begin
          n_fail++;
          $display("FAIL rst_mid_data c=%0d: got %0d want %0d", c, fi.data, e.data);
        end
      end
      reset = (c == 15);
      start = (c == 20);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    @(negedge clk);
    start = 1'b1; num_samples = LW'(3);
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      e = exp_basic(c) | exp_basic(c - 38);
      n_checks++;
      if (flags_now() !== e.flags) begin
        n_fail++;
        $display("FAIL b2b_flags c=%0d: got %b want %b", c, flags_now(), e.flags);
      end
      if (e.flags[4]) begin
        n_checks++;
        if (fi.rd_addr !== e.addr) begin
          n_fail++;
          $display("FAIL b2b_addr c=%0d: got %0d want %0d", c, fi.rd_addr, e.addr);
        end
      end
      if (e.chk) begin
        n_checks++;
        if (fi.data !== e.data) begin
          n_fail++;
          $display("FAIL b2b_data c=%0d: got %0d want %0d", c, fi.data, e.data);
        end
      end
      start = (c == 38);
    end
  endtask

  task automatic test_loopback();
    int  fc_at;
    int  bad_idx;
    bit  fc_seen;
    bit  done_seen;
    for (int i = 0; i < 1000; i++) ram[i] = IW'($urandom_range(0, 7));
    @(negedge clk);
    lb_clr = 1'b1;
    @(negedge clk);
    lb_clr = 1'b0; lb_en = 1'b1;
    start = 1'b1; num_samples = LW'(1000);
    fc_at = -1; fc_seen = 1'b0; done_seen = 1'b0;
    for (int c = 1; c <= 9000 && !done_seen; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (sfc[1] && !fc_seen) begin fc_seen = 1'b1; fc_at = lb_count; end
      if (done) done_seen = 1'b1;
    end
    repeat (4) @(negedge clk);
    lb_en = 1'b0;
    n_checks++;
    if (!done_seen) begin
      n_fail++;
      $display("FAIL loop_done: no done within 9000 cycles");
    end
    n_checks++;
    if (lb_count !== 1000) begin
      n_fail++;
      $display("FAIL loop_strobes: got %0d want 1000", lb_count);
    end
    n_checks++;
    if (lb_bad_valid !== 0) begin
      n_fail++;
      $display("FAIL loop_valid: %0d strobes without sample_valid, want 0", lb_bad_valid);
    end
    n_checks++;
    if (fc_at !== 1000) begin
      n_fail++;
      $display("FAIL loop_cmpl_order: strobes before feed_complete %0d want 1000", fc_at);
    end
    bad_idx = -1;
    for (int i = 0; i < 1000; i++) if (bad_idx < 0 && lb_cap[i] !== ram[i]) bad_idx = i;
    n_checks++;
    if (bad_idx >= 0) begin
      n_fail++;
      $display("FAIL loop_data idx=%0d: got %0d want %0d", bad_idx, lb_cap[bad_idx], ram[bad_idx]);
    end
  endtask

  initial begin
    test_reset();
    test_basic_feed();
    test_zero_length();
    test_start_while_busy();
    test_reset_mid_feed();
    test_back_to_back();
    test_loopback();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sample_feeder.md
Name: sample_feeder

Overview:
- Transmit end of the channel sample-feed interface (clk_sample, sample_valid, feed_reset, feed_complete, data).
- Reads a block of pre-recorded IF samples from a synchronous sample RAM and replays it to a channel top.
- The receiving channel top double-flop synchronizes clk_sample, data, feed_reset and feed_complete, and consumes data on a synchronized rising edge of clk_sample. The feeder therefore generates slow, glitch-free, multi-cycle waveforms.
- Used in the hardware bench and the playback path.

Parameters:
- INPUT_WIDTH, 3: bits per sample; matches the channel data input.
- LEN_WIDTH, 16: width of the sample count and RAM address.
- DIV, 4: clk cycles per clk_sample half-period. Legal range is 3 or more.
- CTRL_CYCLES, 4: length in clk cycles of the feed_reset and feed_complete pulses. Legal range is 3 or more.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a feed. Honoured only in IDLE.
- num_samples  in  LEN_WIDTH  number of samples to send. Latched when start is accepted.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a feed finishes.
- rd_en  out  1  sample RAM read strobe.
- rd_addr  out  LEN_WIDTH  sample RAM address.
- rd_data  in  INPUT_WIDTH  sample RAM data; valid the cycle after rd_en.
- clk_sample  out  1  sample clock to the channel.
- sample_valid  out  1  feed-active qualifier.
- feed_reset  out  1  start-of-feed pulse.
- feed_complete  out  1  end-of-feed pulse.
- data  out  INPUT_WIDTH  current sample.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high; it is sampled on the clk rising edge.
- Reset values: all outputs are 0, the FSM is in IDLE, and the counters are 0.
- Registered outputs: every output is driven straight from a flop, with no combinational paths to the ports.
- FSM states: IDLE, RST, LOAD, LOW, HIGH, TAIL, CMPL.
- IDLE: when start=1, latch num_samples into cnt, clear idx, and go to RST.
- RST: feed_reset=1 for CTRL_CYCLES cycles.
  - If cnt=0, go to CMPL.
  - Otherwise go to LOAD.
- LOAD (1 cycle): rd_en=1, rd_addr=idx. Go to LOW.
- LOW (DIV cycles):
  - clk_sample=0 and sample_valid=1.
  - data is loaded from rd_data at the end of the first LOW cycle, so it changes exactly 1 cycle after the falling edge of clk_sample.
  - data holds until the next LOW phase.
- HIGH (DIV cycles): clk_sample=1 and sample_valid=1. On the last HIGH cycle:
  - If idx+1<cnt: rd_en=1, rd_addr=idx+1, idx increments, go to LOW.
  - Otherwise go to TAIL.
- TAIL (DIV cycles): clk_sample=0 and sample_valid=0. data holds the last sample. This guarantees the final rising edge is fully synchronized before feed_complete asserts.
- CMPL: feed_complete=1 for CTRL_CYCLES cycles. Then go to IDLE, with done=1 in the first IDLE cycle.
- Output behaviour per state:
  - clk_sample is high only in HIGH.
  - sample_valid is high only in LOW and HIGH.
  - feed_reset and feed_complete are never high together.
- Sample period: 2*DIV clk cycles per sample, at 50% duty.
- Data setup: data is stable for at least DIV-1 cycles before each clk_sample rise and for DIV cycles after it.
- Feed duration: from the cycle start is seen to done, the feed takes 1 + CTRL_CYCLES + 1 + 2*DIV*N + DIV + CTRL_CYCLES cycles for N>0, and 1 + 2*CTRL_CYCLES cycles for N=0.
- start while busy: ignored, with no effect on cnt or idx.
- num_samples changing during a feed: no effect.
- N = 2^LEN_WIDTH-1: supported. idx never wraps because the comparison happens before the increment.
- reset mid-feed:
  - Everything is in its reset state on the next cycle.
  - No feed_complete and no done are issued.
  - Any partial feed_reset or feed_complete pulse is truncated.
- rd_en: exactly one pulse per sample, with ascending addresses 0..N-1.

Test Plan:
- Basic feed (DIV=4, CTRL_CYCLES=4, RAM=[5,2,7], N=3; start in cycle 0):
  - feed_reset high in cycles 1-4.
  - rd_en in cycles 5, 13, 21 at addresses 0, 1, 2.
  - clk_sample rises at cycles 10, 18, 26, with data=5, 2, 7 respectively.
  - feed_complete high in cycles 34-37.
  - done in cycle 38.
  - busy high in cycles 1-37.
- Zero-length feed (N=0, start): feed_reset in cycles 1-4, feed_complete in cycles 5-8, done in cycle 9, no rd_en, clk_sample stays 0.
- Loopback (N=1000 random samples into a channel-top-style 2-flop synchronizer plus rising-edge strobe with an accumulating checker):
  - Exactly 1000 strobes, each with sample_valid=1.
  - Captured data equals RAM contents in order.
  - The synchronized feed_complete arrives after the 1000th strobe.
- start asserted in cycles 3 and 20 of a running N=3 feed: ignored; the timing is identical to the basic-feed case.
- reset asserted in cycle 15 of the basic-feed case: from cycle 16 all outputs are 0 and the FSM is in IDLE, with no feed_complete or done. A new start in cycle 20 produces a complete, correct feed.
- Back-to-back feeds (start in the same cycle done pulses, i.e. the first IDLE cycle): accepted; feed_reset asserts the next cycle.
